// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: 2-of-3 majority vote session sequencer with timeout, result hold window and saturating pass count
module vote_session_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int HOLD    = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cast_a,
  input  logic             cast_b,
  input  logic             cast_c,
  input  logic             vote_a,
  input  logic             vote_b,
  input  logic             vote_c,
  output logic             busy,
  output logic [2:0]       voted,
  output logic             result,
  output logic             result_valid,
  output logic             timed_out,
  output logic [CNT_W-1:0] pass_count
);
  localparam int TW = $clog2((TIMEOUT > HOLD) ? TIMEOUT : HOLD) + 1;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RESULT} state_t;
  state_t r_state, w_state_nx;
  logic [TW-1:0] r_timer;
  logic [2:0] r_votes, w_acc, w_voted_nx, w_votes_nx;
  logic w_close_all, w_close_to, w_close, w_hold_done, w_maj;
  // A cast counts only the first time a voter casts in a session
  assign w_acc       = {cast_c, cast_b, cast_a} & ~voted;
  assign w_voted_nx  = voted | w_acc;
  assign w_votes_nx  = (r_votes & ~w_acc) | ({vote_c, vote_b, vote_a} & w_acc);
  assign w_close_all = &w_voted_nx;
  assign w_close_to  = r_timer == TW'(TIMEOUT - 1);
  assign w_close     = w_close_all | w_close_to;
  assign w_hold_done = r_timer == TW'(HOLD - 1);
  assign w_maj       = (w_votes_nx[0] & w_votes_nx[1]) | (w_votes_nx[0] & w_votes_nx[2]) | (w_votes_nx[1] & w_votes_nx[2]);
  assign busy        = r_state != S_IDLE;
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end
  // Next-state selection
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    w_state_nx = start ? S_COLLECT : S_IDLE;
      S_COLLECT: w_state_nx = w_close ? S_RESULT : S_COLLECT;
      S_RESULT:  w_state_nx = w_hold_done ? S_IDLE : S_RESULT;
      default:   w_state_nx = S_IDLE;
    endcase
  end
  // Session datapath: timer, latched votes, result and pass counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer      <= '0;
      r_votes      <= '0;
      voted        <= '0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
      pass_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_timer   <= '0;
          r_votes   <= '0;
          voted     <= '0;
          result    <= 1'b0;
          timed_out <= 1'b0;
        end
        S_COLLECT: begin
          voted   <= w_voted_nx;
          r_votes <= w_votes_nx;
          r_timer <= w_close ? '0 : r_timer + TW'(1);
          if (w_close) begin
            result       <= w_maj;
            result_valid <= 1'b1;
            timed_out    <= ~w_close_all;
            pass_count   <= (w_maj && !(&pass_count)) ? pass_count + CNT_W'(1) : pass_count;
          end
        end
        S_RESULT: begin
          r_timer <= r_timer + TW'(1);
          if (w_hold_done) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
